layer_update_scheduler: RTL and testbench
=========================================

Name: layer_update_scheduler

Overview:
- Sits between the Nios-side write sources and the background / food layer tile RAM write ports of the VGA generator, in the pixel clock domain.
- Buffers tile-RAM write requests from two requesters (background, food) in per-requester FIFOs.
- Commits buffered writes only during vertical blanking, through one shared commit slot with round-robin arbitration.
- Also double-buffers character position data so it changes only at frame boundaries.

Parameters:
- FIFO_DEPTH, 4, entries per requester FIFO; power of 2, at least 2.
- ADDR_W, 4, tile RAM write address width.
- DATA_W, 32, tile RAM / position data width.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  async active-low reset.
- vblank  in  1  level; 1 = vertical blanking (no active lines).
- bg_valid  in  1  background write request.
- bg_ready  out  1  background FIFO can accept.
- bg_addr  in  ADDR_W  background write address.
- bg_data  in  DATA_W  background write data.
- food_valid  in  1  food write request.
- food_ready  out  1  food FIFO can accept.
- food_addr  in  ADDR_W  food write address.
- food_data  in  DATA_W  food write data.
- pos_valid  in  1  position shadow write strobe.
- pos_data  in  DATA_W  new position word.
- bg_wren  out  1  background RAM write enable.
- bg_wraddress  out  ADDR_W  background RAM address.
- bg_wrdata  out  DATA_W  background RAM data.
- food_wren  out  1  food RAM write enable.
- food_wraddress  out  ADDR_W  food RAM address.
- food_wrdata  out  DATA_W  food RAM data.
- position_data  out  DATA_W  frame-stable position word to the character generator.
- frame_done  out  1  one-cycle pulse: both FIFOs drained within the current blank window.
- late  out  1  one-cycle pulse: blank window closed with entries still pending.

Behaviour:
- Reset (async, reset_n=0):
  - All FIFOs empty; pointers, shadow register and position_data = 0.
  - All wren, wraddress, wrdata, frame_done and late = 0.
  - State ACTIVE; round-robin pointer = bg; vblank_d = 0.
  - bg_ready and food_ready = 1 (they equal !full).
- Handshake:
  - An entry is pushed when valid && ready.
  - ready = !full, combinational from the FIFO count only; no pass-through when full, even if a pop occurs that cycle.
  - Requester data is captured on the accepting edge.
- Latency: an entry accepted at edge N can be committed at edge N+1 at the earliest. At most one commit per cycle across both requesters.
- Commit outputs:
  - All commit outputs are registered.
  - The wren for the granted requester is 1 for exactly one cycle; addr and data hold the popped entry.
  - The non-granted wren is 0; its addr and data hold their previous values.
- Arbitration:
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the pointer side; pointer toggles after every grant made with both non-empty.
- Rising-edge detect: vblank_d registered; rise = vblank && !vblank_d; fall = !vblank && vblank_d.
- FSM ACTIVE:
  - No commits.
  - On rise: position_data <= shadow (same edge); go DRAIN.
- FSM DRAIN:
  - One grant per cycle while any FIFO is non-empty.
  - When both FIFOs are empty after the pop (or already empty on entry): pulse frame_done; go BLANK_DONE.
  - On fall: no commit that cycle; if any entry is pending, pulse late; go ACTIVE; pending entries are retained for the next window.
- FSM BLANK_DONE:
  - A new entry arriving returns the FSM to DRAIN; the next frame_done is suppressed until the next window (at most one frame_done per window).
  - On fall: go ACTIVE, no late pulse.
- Position shadow:
  - pos_valid writes the shadow on any cycle; last write wins.
  - If pos_valid coincides with rise, the new pos_data goes straight to position_data.
- Boundaries:
  - Push and pop on the same FIFO in the same cycle: count unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
  - vblank held 1 across reset release: no rise is detected (vblank_d resets to 0 but the FSM ignores rise until vblank_d has been sampled once after reset), so the first window starts at the next genuine rise.
  - reset_n asserted mid-drain: pending entries are discarded.

Test Plan:
- Push 3 bg entries (addr 1,2,3; data A,B,C) with vblank=0 → no bg_wren. Raise vblank → bg_wren on 3 consecutive cycles starting 1 cycle after rise, addr 1,2,3, then frame_done one cycle after the last commit.
- Fill both FIFOs (4 each) during active video → bg_ready=0 and food_ready=0. In blank, grants alternate bg,food,bg,food,…; 8 commits, one per cycle; frame_done once.
- Keep 4 bg entries pending and drop vblank 2 cycles into the window → 2 commits, late pulse, 2 entries retained and committed first in the next window.
- pos_valid with 0x12345678 during active, then 0xCAFEBABE → position_data unchanged until vblank rise, then 0xCAFEBABE; with pos_valid at the rise edge, the same-cycle value is taken.
- Push 1 food entry in BLANK_DONE → food_wren next cycle; no second frame_done in that window.
- Assert reset_n=0 mid-drain → all outputs 0, ready=1, no further commits after release until the next vblank rise.

Source files
------------

// File: rtl/layer_update_if.sv
// -----------------------------------------------------------------------------
// layer_update_if
//
// Groups the write-request side of the layer update scheduler: the background
// and food tile-RAM requesters (valid/ready handshakes with address and data)
// and the position shadow write strobe.
//
// Signals:
//   bg_valid / bg_ready     background write request handshake
//   bg_addr / bg_data       background tile address and data
//   food_valid / food_ready food write request handshake
//   food_addr / food_data   food tile address and data
//   pos_valid / pos_data    position shadow write strobe and value
//
// Modports:
//   master  requester side (Nios bridge / testbench)
//   slave   scheduler side
// -----------------------------------------------------------------------------
interface layer_update_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              bg_valid;
    logic              bg_ready;
    logic [ADDR_W-1:0] bg_addr;
    logic [DATA_W-1:0] bg_data;

    logic              food_valid;
    logic              food_ready;
    logic [ADDR_W-1:0] food_addr;
    logic [DATA_W-1:0] food_data;

    logic              pos_valid;
    logic [DATA_W-1:0] pos_data;

    modport master (
        output bg_valid, bg_addr, bg_data,
        input  bg_ready,
        output food_valid, food_addr, food_data,
        input  food_ready,
        output pos_valid, pos_data
    );

    modport slave (
        input  bg_valid, bg_addr, bg_data,
        output bg_ready,
        input  food_valid, food_addr, food_data,
        output food_ready,
        input  pos_valid, pos_data
    );
endinterface

// File: rtl/layer_update_scheduler.sv
// -----------------------------------------------------------------------------
// layer_update_scheduler
//
// Buffers tile-RAM writes from the background and food requesters in two
// small FIFOs and commits them to the VGA generator's tile RAMs only while the
// raster is in vertical blanking, so the visible frame never tears. One
// commit slot is shared by both requesters with round-robin arbitration when
// both have work. A shadow register double-buffers the character position
// word so the character generator sees a new value only at a frame boundary.
//
// Ports:
//   clk             pixel clock
//   reset_n         asynchronous active-low reset
//   vblank          1 = vertical blanking
//   req             requester interface (slave modport): bg/food handshakes
//                   and the position shadow strobe
//   bg_wren         background RAM write enable (one-cycle pulse per commit)
//   bg_wraddress    background RAM write address (holds last committed)
//   bg_wrdata       background RAM write data    (holds last committed)
//   food_wren       food RAM write enable
//   food_wraddress  food RAM write address
//   food_wrdata     food RAM write data
//   position_data   frame-stable position word
//   frame_done      pulse: both FIFOs drained inside the current blank window
//   late            pulse: blank window closed with entries still pending
// -----------------------------------------------------------------------------
module layer_update_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vblank,
    layer_update_if.slave     req,
    output logic              bg_wren,
    output logic [ADDR_W-1:0] bg_wraddress,
    output logic [DATA_W-1:0] bg_wrdata,
    output logic              food_wren,
    output logic [ADDR_W-1:0] food_wraddress,
    output logic [DATA_W-1:0] food_wrdata,
    output logic [DATA_W-1:0] position_data,
    output logic              frame_done,
    output logic              late
);

    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int ENTRY_W  = ADDR_W + DATA_W;
    localparam int NREQ     = 2;
    localparam int REQ_BG   = 0;
    localparam int REQ_FOOD = 1;

    typedef enum logic [1:0] {
        ST_ACTIVE     = 2'd0,   // visible lines: hold all writes
        ST_DRAIN      = 2'd1,   // blanking: commit one entry per cycle
        ST_BLANK_DONE = 2'd2    // blanking, FIFOs drained this window
    } state_t;

    state_t state;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Requester FIFOs (index 0 = background, 1 = food)
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [NREQ][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr   [NREQ];
    logic [PTR_W-1:0]   rd_ptr   [NREQ];
    logic [CNT_W-1:0]   count    [NREQ];
    logic [ENTRY_W-1:0] in_entry [NREQ];
    logic [ENTRY_W-1:0] head     [NREQ];

    logic [NREQ-1:0] in_valid;
    logic [NREQ-1:0] full;
    logic [NREQ-1:0] nonempty;
    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;

    assign in_valid[REQ_BG]   = req.bg_valid;
    assign in_valid[REQ_FOOD] = req.food_valid;
    assign in_entry[REQ_BG]   = {req.bg_addr, req.bg_data};
    assign in_entry[REQ_FOOD] = {req.food_addr, req.food_data};

    // Ready depends on the stored count only: a pop in the same cycle does
    // not open a slot for a full FIFO.
    assign req.bg_ready   = !full[REQ_BG];
    assign req.food_ready = !full[REQ_FOOD];

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first) so no latch is inferred.
    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int i = 0; i < NREQ; i++) begin
            full[i]     = (count[i] == CNT_W'(FIFO_DEPTH));
            nonempty[i] = (count[i] != '0);
            push[i]     = in_valid[i] && !full[i];
            head[i]     = fifo_mem[i][rd_ptr[i]];
        end
    end

    // NOTE: storage arrays carry no reset; emptiness is defined by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= in_entry[i];
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                // Depth is a power of two, so pointers wrap naturally.
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Blanking edge detection
    // -------------------------------------------------------------------------
    logic vblank_d;
    logic edge_armed;   // set once vblank_d holds a real sample after reset
    logic rise;
    logic fall;

    // Without edge_armed, vblank held high through reset release would look
    // like a rising edge and open a window mid-blank.
    assign rise = vblank && !vblank_d && edge_armed;
    assign fall = !vblank && vblank_d;

    // -------------------------------------------------------------------------
    // Commit arbitration
    // -------------------------------------------------------------------------
    logic rr_food;      // 1 = food wins the next contended grant
    logic commit;
    logic grant_food;
    logic any_pending;

    assign any_pending = |nonempty;

    // The closing edge of the window never commits, so a write cannot land
    // on the first visible line.
    always_comb begin
        commit     = 1'b0;
        grant_food = 1'b0;
        if ((state == ST_DRAIN || state == ST_BLANK_DONE) && !fall && any_pending) begin
            commit     = 1'b1;
            grant_food = (&nonempty) ? rr_food : nonempty[REQ_FOOD];
        end
        pop           = '0;
        pop[REQ_BG]   = commit && !grant_food;
        pop[REQ_FOOD] = commit && grant_food;
    end

    // -------------------------------------------------------------------------
    // Window FSM
    // -------------------------------------------------------------------------
    logic done_seen;        // frame_done already issued in this window
    logic done_seen_next;
    logic frame_done_next;
    logic late_next;

    always_comb begin
        state_next      = state;
        done_seen_next  = done_seen;
        frame_done_next = 1'b0;
        late_next       = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (rise) begin
                    state_next     = ST_DRAIN;
                    done_seen_next = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (fall) begin
                    // Pending entries stay queued for the next window.
                    state_next = ST_ACTIVE;
                    late_next  = any_pending;
                end else if (!any_pending) begin
                    // Counts already reflect the previous pop, so the pulse
                    // lands one cycle after the last commit.
                    state_next      = ST_BLANK_DONE;
                    frame_done_next = !done_seen;
                    done_seen_next  = 1'b1;
                end
            end
            ST_BLANK_DONE: begin
                if (fall) begin
                    state_next = ST_ACTIVE;
                end else if (any_pending) begin
                    // The late arrival is committed this cycle by the arbiter.
                    state_next = ST_DRAIN;
                end
            end
            default: begin
                state_next = ST_ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_ACTIVE;
            vblank_d   <= 1'b0;
            edge_armed <= 1'b0;
            done_seen  <= 1'b0;
            rr_food    <= 1'b0;
            frame_done <= 1'b0;
            late       <= 1'b0;
        end else begin
            state      <= state_next;
            vblank_d   <= vblank;
            edge_armed <= 1'b1;
            done_seen  <= done_seen_next;
            frame_done <= frame_done_next;
            late       <= late_next;
            // Priority only rotates when both requesters actually contended.
            if (commit && (&nonempty)) begin
                rr_food <= !rr_food;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered commit outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bg_wren        <= 1'b0;
            bg_wraddress   <= '0;
            bg_wrdata      <= '0;
            food_wren      <= 1'b0;
            food_wraddress <= '0;
            food_wrdata    <= '0;
        end else begin
            bg_wren   <= pop[REQ_BG];
            food_wren <= pop[REQ_FOOD];
            if (pop[REQ_BG]) begin
                bg_wraddress <= head[REQ_BG][ENTRY_W-1:DATA_W];
                bg_wrdata    <= head[REQ_BG][DATA_W-1:0];
            end
            if (pop[REQ_FOOD]) begin
                food_wraddress <= head[REQ_FOOD][ENTRY_W-1:DATA_W];
                food_wrdata    <= head[REQ_FOOD][DATA_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Position double buffer
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] pos_shadow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_shadow    <= '0;
            position_data <= '0;
        end else begin
            if (req.pos_valid) begin
                pos_shadow <= req.pos_data;
            end
            // A write on the frame-boundary edge bypasses the shadow so the
            // newest value is not deferred by a whole frame.
            if (state == ST_ACTIVE && rise) begin
                position_data <= req.pos_valid ? req.pos_data : pos_shadow;
            end
        end
    end

endmodule

// File: tb/tb_layer_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_layer_update_scheduler
//
// Directed testbench for layer_update_scheduler. Inputs are driven 1 time
// unit after the rising clock edge and outputs are sampled at the same point,
// so every sample reflects the edge that has just occurred.
// -----------------------------------------------------------------------------
module tb_layer_update_scheduler;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 32;

    logic              clk;
    logic              reset_n;
    logic              vblank;
    logic              bg_wren;
    logic [ADDR_W-1:0] bg_wraddress;
    logic [DATA_W-1:0] bg_wrdata;
    logic              food_wren;
    logic [ADDR_W-1:0] food_wraddress;
    logic [DATA_W-1:0] food_wrdata;
    logic [DATA_W-1:0] position_data;
    logic              frame_done;
    logic              late;

    int checks = 0;
    int errors = 0;

    layer_update_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_if ();

    layer_update_scheduler #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vblank        (vblank),
        .req           (req_if),
        .bg_wren       (bg_wren),
        .bg_wraddress  (bg_wraddress),
        .bg_wrdata     (bg_wrdata),
        .food_wren     (food_wren),
        .food_wraddress(food_wraddress),
        .food_wrdata   (food_wrdata),
        .position_data (position_data),
        .frame_done    (frame_done),
        .late          (late)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_if.bg_valid   = 1'b0;
        req_if.bg_addr    = '0;
        req_if.bg_data    = '0;
        req_if.food_valid = 1'b0;
        req_if.food_addr  = '0;
        req_if.food_data  = '0;
        req_if.pos_valid  = 1'b0;
        req_if.pos_data   = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        vblank  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
    endtask

    // One-cycle push on either or both requesters.
    task automatic push(input logic bg_en, input logic [ADDR_W-1:0] bg_a, input logic [DATA_W-1:0] bg_d,
                        input logic food_en, input logic [ADDR_W-1:0] food_a, input logic [DATA_W-1:0] food_d);
        req_if.bg_valid   = bg_en;
        req_if.bg_addr    = bg_a;
        req_if.bg_data    = bg_d;
        req_if.food_valid = food_en;
        req_if.food_addr  = food_a;
        req_if.food_data  = food_d;
        step();
        req_if.bg_valid   = 1'b0;
        req_if.food_valid = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        vblank  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bg_wren, food_wren, frame_done, late} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 0000", {bg_wren, food_wren, frame_done, late});
        end
        checks++;
        if ({req_if.bg_ready, req_if.food_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 11", {req_if.bg_ready, req_if.food_ready});
        end
        checks++;
        if ({bg_wraddress, food_wraddress} !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 00", {bg_wraddress, food_wraddress});
        end
        checks++;
        if ({bg_wrdata, food_wrdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {bg_wrdata, food_wrdata});
        end
        checks++;
        if (position_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_position: got %h expected 0", position_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_bg_drain();
        logic [DATA_W-1:0] exp_d [3];
        logic              wren_seen;
        exp_d[0] = 32'hAAAA_0001;
        exp_d[1] = 32'hBBBB_0002;
        exp_d[2] = 32'hCCCC_0003;
        apply_reset();
        wren_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(1'b1, ADDR_W'(k + 1), exp_d[k], 1'b0, '0, '0);
            wren_seen |= bg_wren | food_wren;
        end
        repeat (3) begin
            step();
            wren_seen |= bg_wren | food_wren;
        end
        checks++;
        if (wren_seen !== 1'b0) begin
            errors++;
            $display("FAIL bg_drain_active_hold: got wren %b expected 0", wren_seen);
        end
        vblank = 1'b1;
        step();     // rising edge of the window
        checks++;
        if (bg_wren !== 1'b0) begin
            errors++;
            $display("FAIL bg_drain_rise_edge: got wren %b expected 0", bg_wren);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({bg_wren, food_wren, frame_done} !== 3'b100) begin
                errors++;
                $display("FAIL bg_drain_commit%0d_flags: got %b expected 100", k, {bg_wren, food_wren, frame_done});
            end
            checks++;
            if (bg_wraddress !== ADDR_W'(k + 1) || bg_wrdata !== exp_d[k]) begin
                errors++;
                $display("FAIL bg_drain_commit%0d_entry: got %h/%h expected %h/%h",
                         k, bg_wraddress, bg_wrdata, ADDR_W'(k + 1), exp_d[k]);
            end
        end
        step();
        checks++;
        if ({bg_wren, frame_done} !== 2'b01) begin
            errors++;
            $display("FAIL bg_drain_frame_done: got wren,done %b expected 01", {bg_wren, frame_done});
        end
        step();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL bg_drain_frame_done_width: got %b expected 0", frame_done);
        end
        vblank = 1'b0;
        step();
        step();
        checks++;
        if (late !== 1'b0) begin
            errors++;
            $display("FAIL bg_drain_no_late: got %b expected 0", late);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_fill_both();
        int   done_pulses;
        int   wren_cycles;
        logic is_food;
        int   idx;
        apply_reset();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            push(1'b1, ADDR_W'(4 + i), 32'hB000_0000 + 32'(i),
                 1'b1, ADDR_W'(8 + i), 32'hF000_0000 + 32'(i));
        end
        checks++;
        if ({req_if.bg_ready, req_if.food_ready} !== 2'b00) begin
            errors++;
            $display("FAIL fill_ready_full: got %b expected 00", {req_if.bg_ready, req_if.food_ready});
        end
        // Offered while full: must be dropped by the handshake.
        push(1'b1, 4'hF, 32'hDEAD_0000, 1'b1, 4'hE, 32'hDEAD_0001);
        vblank = 1'b1;
        step();     // rise
        done_pulses = 0;
        wren_cycles = 0;
        for (int k = 0; k < 2 * FIFO_DEPTH; k++) begin
            step();
            is_food = k[0];
            idx     = k / 2;
            wren_cycles += (bg_wren || food_wren) ? 1 : 0;
            done_pulses += frame_done ? 1 : 0;
            checks++;
            if ({bg_wren, food_wren} !== {!is_food, is_food}) begin
                errors++;
                $display("FAIL fill_grant%0d: got bg,food %b expected %b", k, {bg_wren, food_wren}, {!is_food, is_food});
            end
            if (is_food) begin
                checks++;
                if (food_wraddress !== ADDR_W'(8 + idx) || food_wrdata !== 32'hF000_0000 + 32'(idx)) begin
                    errors++;
                    $display("FAIL fill_food_entry%0d: got %h/%h expected %h/%h", k, food_wraddress, food_wrdata,
                             ADDR_W'(8 + idx), 32'hF000_0000 + 32'(idx));
                end
            end else begin
                checks++;
                if (bg_wraddress !== ADDR_W'(4 + idx) || bg_wrdata !== 32'hB000_0000 + 32'(idx)) begin
                    errors++;
                    $display("FAIL fill_bg_entry%0d: got %h/%h expected %h/%h", k, bg_wraddress, bg_wrdata,
                             ADDR_W'(4 + idx), 32'hB000_0000 + 32'(idx));
                end
            end
            if (k == 1) begin
                checks++;
                if (bg_wraddress !== 4'h4 || bg_wrdata !== 32'hB000_0000) begin
                    errors++;
                    $display("FAIL fill_bg_hold: got %h/%h expected 4/b0000000", bg_wraddress, bg_wrdata);
                end
                checks++;
                if (req_if.bg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_bg_ready_after_pop: got %b expected 1", req_if.bg_ready);
                end
            end
        end
        repeat (4) begin
            step();
            wren_cycles += (bg_wren || food_wren) ? 1 : 0;
            done_pulses += frame_done ? 1 : 0;
        end
        checks++;
        if (wren_cycles !== 2 * FIFO_DEPTH) begin
            errors++;
            $display("FAIL fill_commit_count: got %0d expected %0d", wren_cycles, 2 * FIFO_DEPTH);
        end
        checks++;
        if (done_pulses !== 1) begin
            errors++;
            $display("FAIL fill_frame_done_count: got %0d expected 1", done_pulses);
        end
        vblank = 1'b0;
        step();
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_late();
        int wren_cycles;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push(1'b1, ADDR_W'(1 + i), 32'hD000_0001 + 32'(i), 1'b0, '0, '0);
        end
        vblank = 1'b1;
        step();     // rise
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (bg_wren !== 1'b1 || bg_wraddress !== ADDR_W'(1 + k)) begin
                errors++;
                $display("FAIL late_first_window%0d: got wren %b addr %h expected 1 %h", k, bg_wren, bg_wraddress, ADDR_W'(1 + k));
            end
        end
        vblank = 1'b0;
        step();     // window closes
        checks++;
        if ({bg_wren, late} !== 2'b01) begin
            errors++;
            $display("FAIL late_pulse: got wren,late %b expected 01", {bg_wren, late});
        end
        step();
        checks++;
        if (late !== 1'b0) begin
            errors++;
            $display("FAIL late_pulse_width: got %b expected 0", late);
        end
        wren_cycles = 0;
        repeat (3) begin
            step();
            wren_cycles += bg_wren ? 1 : 0;
        end
        checks++;
        if (wren_cycles !== 0) begin
            errors++;
            $display("FAIL late_active_hold: got %0d commits expected 0", wren_cycles);
        end
        vblank = 1'b1;
        step();     // rise of next window
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (bg_wren !== 1'b1 || bg_wraddress !== ADDR_W'(3 + k) || bg_wrdata !== 32'hD000_0003 + 32'(k)) begin
                errors++;
                $display("FAIL late_retained%0d: got %b %h/%h expected 1 %h/%h", k, bg_wren, bg_wraddress, bg_wrdata,
                         ADDR_W'(3 + k), 32'hD000_0003 + 32'(k));
            end
        end
        step();
        checks++;
        if ({bg_wren, frame_done} !== 2'b01) begin
            errors++;
            $display("FAIL late_second_done: got wren,done %b expected 01", {bg_wren, frame_done});
        end
        vblank = 1'b0;
        step();
        step();
        checks++;
        if (late !== 1'b0) begin
            errors++;
            $display("FAIL late_none_after_drain: got %b expected 0", late);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_position();
        apply_reset();
        req_if.pos_valid = 1'b1;
        req_if.pos_data  = 32'h1234_5678;
        step();
        req_if.pos_data  = 32'hCAFE_BABE;
        step();
        req_if.pos_valid = 1'b0;
        step();
        checks++;
        if (position_data !== 32'h0) begin
            errors++;
            $display("FAIL pos_active_hold: got %h expected 00000000", position_data);
        end
        vblank = 1'b1;
        step();     // rise
        checks++;
        if (position_data !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL pos_frame_update: got %h expected cafebabe", position_data);
        end
        step();
        vblank = 1'b0;
        step();
        req_if.pos_valid = 1'b1;
        req_if.pos_data  = 32'h1111_1111;
        step();
        req_if.pos_valid = 1'b0;
        step();
        checks++;
        if (position_data !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL pos_second_hold: got %h expected cafebabe", position_data);
        end
        vblank           = 1'b1;
        req_if.pos_valid = 1'b1;
        req_if.pos_data  = 32'hDEAD_BEEF;
        step();     // rise with a coincident write
        checks++;
        if (position_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL pos_same_cycle: got %h expected deadbeef", position_data);
        end
        req_if.pos_data = 32'h5555_5555;
        step();
        req_if.pos_valid = 1'b0;
        step();
        checks++;
        if (position_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL pos_blank_hold: got %h expected deadbeef", position_data);
        end
        vblank = 1'b0;
        step();
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_blank_done_push();
        int done_pulses;
        int bg_seen;
        apply_reset();
        vblank = 1'b1;
        step();     // rise
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL bd_rise_done: got %b expected 0", frame_done);
        end
        step();
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL bd_empty_done: got %b expected 1", frame_done);
        end
        push(1'b0, '0, '0, 1'b1, 4'h9, 32'hF00D_0009);
        checks++;
        if (food_wren !== 1'b0) begin
            errors++;
            $display("FAIL bd_accept_edge: got %b expected 0", food_wren);
        end
        done_pulses = frame_done ? 1 : 0;
        step();
        done_pulses += frame_done ? 1 : 0;
        checks++;
        if (food_wren !== 1'b1 || food_wraddress !== 4'h9 || food_wrdata !== 32'hF00D_0009) begin
            errors++;
            $display("FAIL bd_food_commit: got %b %h/%h expected 1 9/f00d0009", food_wren, food_wraddress, food_wrdata);
        end
        bg_seen = bg_wren ? 1 : 0;
        step();
        checks++;
        if (food_wren !== 1'b0) begin
            errors++;
            $display("FAIL bd_food_single: got %b expected 0", food_wren);
        end
        repeat (4) begin
            done_pulses += frame_done ? 1 : 0;
            bg_seen     += bg_wren ? 1 : 0;
            step();
        end
        checks++;
        if (done_pulses !== 0) begin
            errors++;
            $display("FAIL bd_no_second_done: got %0d expected 0", done_pulses);
        end
        checks++;
        if (bg_seen !== 0 || bg_wraddress !== 4'h0) begin
            errors++;
            $display("FAIL bd_bg_idle: got %0d commits addr %h expected 0 0", bg_seen, bg_wraddress);
        end
        vblank = 1'b0;
        step();
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_drain();
        int wren_cycles;
        int done_pulses;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push(1'b1, ADDR_W'(1 + i), 32'hE000_0001 + 32'(i), (i < 2), ADDR_W'(10 + i), 32'hC000_0000 + 32'(i));
        end
        vblank = 1'b1;
        step();     // rise
        step();
        checks++;
        if ({bg_wren, food_wren} !== 2'b10 || bg_wraddress !== 4'h1) begin
            errors++;
            $display("FAIL rmd_first_grant: got %b addr %h expected 10 1", {bg_wren, food_wren}, bg_wraddress);
        end
        step();
        checks++;
        if ({bg_wren, food_wren} !== 2'b01 || food_wraddress !== 4'hA) begin
            errors++;
            $display("FAIL rmd_second_grant: got %b addr %h expected 01 a", {bg_wren, food_wren}, food_wraddress);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if ({bg_wren, food_wren, frame_done, late, req_if.bg_ready, req_if.food_ready} !== 6'b000011) begin
            errors++;
            $display("FAIL rmd_outputs: got %b expected 000011",
                     {bg_wren, food_wren, frame_done, late, req_if.bg_ready, req_if.food_ready});
        end
        checks++;
        if ({bg_wraddress, food_wraddress, bg_wrdata, food_wrdata} !== 72'h0) begin
            errors++;
            $display("FAIL rmd_addr_data: got %h expected 0", {bg_wraddress, food_wraddress, bg_wrdata, food_wrdata});
        end
        @(negedge clk);
        reset_n = 1'b1;     // vblank still high through release
        wren_cycles = 0;
        done_pulses = 0;
        repeat (10) begin
            step();
            wren_cycles += (bg_wren || food_wren) ? 1 : 0;
            done_pulses += frame_done ? 1 : 0;
        end
        checks++;
        if (wren_cycles !== 0 || done_pulses !== 0) begin
            errors++;
            $display("FAIL rmd_no_window_after_release: got %0d commits %0d done expected 0 0", wren_cycles, done_pulses);
        end
        vblank = 1'b0;
        step();
        step();
        vblank = 1'b1;
        repeat (6) begin
            step();
            wren_cycles += (bg_wren || food_wren) ? 1 : 0;
            done_pulses += frame_done ? 1 : 0;
        end
        checks++;
        if (wren_cycles !== 0 || done_pulses !== 1) begin
            errors++;
            $display("FAIL rmd_entries_discarded: got %0d commits %0d done expected 0 1", wren_cycles, done_pulses);
        end
        vblank = 1'b0;
        step();
        step();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_bg_drain();
        test_fill_both();
        test_late();
        test_position();
        test_blank_done_push();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
